// File: rtl/fb_mem_loader_pkg.sv
// Shared definitions for the FB CPU program memory subsystem.
package fb_mem_loader_pkg;

  localparam int FB_AW    = 6;
  localparam int FB_DW    = 10;
  localparam int FB_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_spram.sv
// Single-port synchronous RAM, registered read, old data returned on read-during-write.
module fb_spram #(
  parameter int AW = 6,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read samples the array before this edge's write lands, giving old data.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[addr];
  end

endmodule

// File: rtl/fb_mem_loader.sv
// Program RAM for the FB CPU: zeroes itself after reset, takes a program over a
// valid/ready stream from address 0, then releases the CPU and hands it the RAM port.
module fb_mem_loader
  import fb_mem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FB_AW,
  parameter int DATA_WIDTH    = FB_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  input  logic                     ld_start,
  output logic                     cpu_rst,
  input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
  input  logic                     cpu_wr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic [ADDRESS_WIDTH:0]   ld_count,
  output logic                     ld_ovf,
  output logic                     running
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW:0]   MAX_COUNT = {1'b1, {AW{1'b0}}};

  fb_state_t     state, state_nxt;
  logic [AW-1:0] clr_addr;
  logic [AW-1:0] ld_addr;
  logic          hs;
  logic          ld_take;
  logic          port_we;
  logic [AW-1:0] port_addr;
  logic [DW-1:0] port_wdata;

  assign ld_ready = (state == ST_LOAD);
  assign hs       = ld_valid && ld_ready;
  // A restart in the same cycle discards the word on the bus.
  assign ld_take  = hs && !ld_start;

  always_comb begin
    state_nxt  = state;
    port_we    = 1'b0;
    port_addr  = ld_addr;
    port_wdata = ld_data;
    case (state)
      ST_CLEAR: begin
        port_we    = 1'b1;
        port_addr  = clr_addr;
        port_wdata = '0;
        if (clr_addr == LAST_ADDR) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        port_we = ld_take;
        if (ld_take && (ld_last || ld_addr == LAST_ADDR)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        port_we    = cpu_wr;
        port_addr  = cpu_mar;
        port_wdata = cpu_wdata;
        if (ld_start) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_CLEAR;
    endcase
    if (rst) port_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      ld_addr  <= '0;
      ld_count <= '0;
      ld_ovf   <= 1'b0;
      cpu_rst  <= 1'b1;
      running  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Release lags RUN entry by a cycle; an abort re-asserts reset immediately.
      cpu_rst <= !(state == ST_RUN && state_nxt == ST_RUN);
      running <= (state == ST_RUN && state_nxt == ST_RUN);
      if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
      if (ld_start && state != ST_CLEAR) begin
        ld_addr  <= '0;
        ld_count <= '0;
        ld_ovf   <= 1'b0;
      end else if (state == ST_LOAD && hs) begin
        if (ld_addr != LAST_ADDR) ld_addr <= ld_addr + 1'b1;
        else if (!ld_last)        ld_ovf  <= 1'b1;
        if (ld_count != MAX_COUNT) ld_count <= ld_count + 1'b1;
      end
    end
  end

  fb_spram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (port_we),
    .addr  (port_addr),
    .wdata (port_wdata),
    .rdata (cpu_rdata)
  );

endmodule

// File: tb/tb_fb_mem_loader.sv
// Randomized bench for fb_mem_loader with a behavioural memory/program model.
module tb_fb_mem_loader;
  import fb_mem_loader_pkg::*;

  localparam int AW    = FB_AW;
  localparam int DW    = FB_DW;
  localparam int DEPTH = FB_DEPTH;

  logic          clk;
  logic          rst;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_start;
  logic          cpu_rst;
  logic [AW-1:0] cpu_mar;
  logic          cpu_wr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic [AW:0]   ld_count;
  logic          ld_ovf;
  logic          running;

  fb_mem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_start  (ld_start),
    .cpu_rst   (cpu_rst),
    .cpu_mar   (cpu_mar),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ld_count  (ld_count),
    .ld_ovf    (ld_ovf),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset, then the RAM is expected to spend exactly DEPTH cycles zeroing itself.
  task automatic do_reset;
    int n;
    rst = 1'b1; ld_valid = 1'b0; ld_start = 1'b0; cpu_wr = 1'b0;
    tick;
    rst = 1'b0;
    check("rst_ld_count", 32'(ld_count), 32'd0);
    check("rst_ld_ovf", 32'(ld_ovf), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
    n = 0;
    while (!ld_ready && n < 200) begin
      check("clear_cpu_rst", 32'(cpu_rst), 32'd1);
      tick;
      n++;
    end
    check("clear_cycles", 32'(n), 32'(DEPTH));
  endtask

  task automatic start_load;
    ld_start = 1'b1;
    tick;
    ld_start = 1'b0;
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("start_ld_ready", 32'(ld_ready), 32'd1);
    check("start_ld_count", 32'(ld_count), 32'd0);
    check("start_ld_ovf", 32'(ld_ovf), 32'd0);
    check("start_running", 32'(running), 32'd0);
  endtask

  // Streams words from address 0 with random idle gaps and random CPU-port noise.
  task automatic load_list(input logic [DW-1:0] words[$], input bit use_last, input bit complete);
    int sent;
    sent = 0;
    while (sent < words.size()) begin
      cpu_wr = 1'($urandom); cpu_mar = AW'($urandom); cpu_wdata = DW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0; ld_data = DW'($urandom); ld_last = 1'($urandom);
        tick;
      end else begin
        check("ld_ready", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1;
        ld_data  = words[sent];
        ld_last  = use_last && (sent == words.size() - 1);
        tick;
        exp_mem[sent] = words[sent];
        sent++;
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0; cpu_wr = 1'b0;
    check("ld_count", 32'(ld_count), 32'(words.size()));
    if (complete) begin
      check("ld_ovf", 32'(ld_ovf), 32'(!use_last));
      check("entry_running", 32'(running), 32'd0);
      check("entry_cpu_rst", 32'(cpu_rst), 32'd1);
      check("run_ld_ready", 32'(ld_ready), 32'd0);
      tick;
      check("run_running", 32'(running), 32'd1);
      check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    end
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      cpu_wr  = 1'b0;
      cpu_mar = AW'(a);
      tick;
      check($sformatf("%s[%0d]", tag, a), 32'(cpu_rdata), 32'(exp_mem[a]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] q[$];
    int n;
    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; ld_start = 1'b0;
    cpu_mar = '0; cpu_wr = 1'b0; cpu_wdata = '0;
    tick;

    do_reset;
    q = '{DW'(10'h005), DW'(10'h046), DW'(10'h180)};
    load_list(q, 1'b1, 1'b1);
    cpu_mar = AW'(1);
    tick;
    check("fetch_addr1", 32'(cpu_rdata), 32'h046);
    readback("after_clear");

    // CPU write with a same-address read in the same cycle.
    cpu_wr = 1'b1; cpu_mar = AW'(10); cpu_wdata = DW'(10'h3FF);
    tick;
    check("rdw_old_data", 32'(cpu_rdata), 32'(exp_mem[10]));
    exp_mem[10] = DW'(10'h3FF);
    cpu_wr = 1'b0;
    tick;
    check("cpu_write_read", 32'(cpu_rdata), 32'h3FF);

    // Overflow: full-depth stream with no last marker.
    start_load;
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(DW'($urandom));
    load_list(q, 1'b0, 1'b1);
    readback("overflow");

    // Restart colliding with a last handshake: restart wins, no write, no RUN.
    start_load;
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = DW'(10'h2AA); ld_start = 1'b1;
    tick;
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
    check("collide_ld_ready", 32'(ld_ready), 32'd1);
    check("collide_ld_count", 32'(ld_count), 32'd0);
    q = '{DW'(10'h1C0)};
    load_list(q, 1'b1, 1'b1);
    readback("reload_one");

    for (int r = 0; r < 4; r++) begin
      start_load;
      n = $urandom_range(1, 70);
      q.delete();
      for (int i = 0; i < ((n > DEPTH) ? DEPTH : n); i++) q.push_back(DW'($urandom));
      load_list(q, n <= DEPTH, 1'b1);
      readback("random");
    end

    // Reset in the middle of a load wipes everything.
    start_load;
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(DW'($urandom) | DW'(1));
    load_list(q, 1'b0, 1'b0);
    do_reset;
    q = '{DW'(10'h155)};
    load_list(q, 1'b1, 1'b1);
    readback("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
